ifu_dreg: RTL and testbench
===========================

Name: ifu_dreg

Overview:
- Fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Holds the fetch PC and drives the instruction-memory address.
- Selects the next PC from the D-stage control decode (NPCOp) and the D-stage branch compare, with delay-slot semantics.
- Latches the fetched instruction and its PC into the D stage, where the controller decodes it.

Parameters:
- PC_RESET, 32'h0000_3000, fetch PC after reset.
- NPC_ADD4, 3'd0, NPCOp code: sequential.
- NPC_BEQ, 3'd1, NPCOp code: conditional branch.
- NPC_JAL, 3'd2, NPCOp code: jump-and-link.
- NPC_JR, 3'd3, NPCOp code: jump register.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from the hazard unit; freezes F_PC and the D registers.
- D_NPCOp  in  3  next-PC mode from the controller decoding D_IR.
- D_cmp_eq  in  1  forwarded rs==rt result for the D-stage instruction.
- D_rs_data  in  32  forwarded rs value for the D-stage instruction (jr target).
- F_instr  in  32  instruction read combinationally from IM at F_PC.
- F_PC  out  32  current fetch PC; IM address.
- D_IR  out  32  instruction registered into D.
- D_PC  out  32  PC of D_IR.
- D_PC8  out  32  D_PC+8, the jal link value.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge): F_PC=PC_RESET, D_IR=0 (nop), D_PC=PC_RESET. D_PC8 follows as PC_RESET+8. reset overrides stall and all redirects.
- Next-PC (combinational, from D-stage values):
  - ADD4: npc=F_PC+4.
  - BEQ: taken when D_cmp_eq=1, npc=D_PC+4+(sext(D_IR[15:0])<<2); otherwise npc=F_PC+4.
  - JAL: npc={D_PC[31:28],D_IR[25:0],2'b00}.
  - JR: npc=D_rs_data.
  - Codes 3'd4..3'd7: treated as ADD4.
- All arithmetic is 32-bit modulo 2^32; no overflow detection. Branch offset is sign-extended before the shift.
- Delay slot: the instruction at D_PC+4 is already in F when a redirect is taken. It is never squashed and always enters D on the following edge.
- Normal edge (stall=0): F_PC<=npc; D_IR<=F_instr; D_PC<=F_PC.
- Stall edge (stall=1): F_PC, D_IR and D_PC all hold. The redirect is not applied, because the D-stage operands may be stale; it is reevaluated when stall falls. The bubble is inserted downstream, not by this block.
- Latency: an instruction fetched at cycle n appears on D_IR at n+1 if unstalled. A redirect decoded in D at cycle n sets F_PC to the target at n+1.
- Boundaries:
  - Back-to-back redirects (branch in a delay slot) are undefined by ISA, but the block must still follow the rule "npc from the current D instruction".
  - Stall asserted for k cycles delays everything by exactly k cycles with no lost or duplicated instruction.
  - Reset asserted mid-stall or mid-redirect: the next edge yields the reset values.
  - jr to a non-word-aligned target is passed through unchanged; there is no alignment trap.
- No internal FSM beyond the PC/D registers; state = {F_PC, D_IR, D_PC}.

Test Plan:
- Reset then 3 unstalled cycles with D_NPCOp=0 -> F_PC=0x3000, 0x3004, 0x3008, 0x300C. D_PC lags F_PC by one cycle; D_IR equals the prior F_instr.
- beq in D at D_PC=0x3004, imm=0xFFFF, D_cmp_eq=1 -> next F_PC=0x3004. With D_cmp_eq=0 -> next F_PC=0x300C. The delay slot (0x3008) enters D in both cases.
- jal in D at D_PC=0x3010, D_IR[25:0]=26'h0000C10 -> next F_PC=0x00003040, D_PC8=0x3018.
- jr in D with D_rs_data=0x0000_3100 and stall=1 for 2 cycles -> F_PC, D_IR and D_PC frozen for 2 edges. F_PC becomes 0x3100 on the first edge with stall=0.
- reset=1 asserted together with stall=1 and D_NPCOp=JR -> F_PC=0x3000, D_IR=0 after that edge.
- D_NPCOp=3'd7 -> behaves as ADD4 (F_PC+4).

Source files
------------

// File: rtl/ifu_dreg_if.sv
// ifu_dreg_if: fetch-stage control inputs and IF/ID register outputs
interface ifu_dreg_if;
    logic        stall;
    logic [2:0]  D_NPCOp;
    logic        D_cmp_eq;
    logic [31:0] D_rs_data;
    logic [31:0] F_instr;
    logic [31:0] F_PC;
    logic [31:0] D_IR;
    logic [31:0] D_PC;
    logic [31:0] D_PC8;
    modport master (
        output stall, D_NPCOp, D_cmp_eq, D_rs_data, F_instr,
        input  F_PC, D_IR, D_PC, D_PC8
    );
    modport slave (
        input  stall, D_NPCOp, D_cmp_eq, D_rs_data, F_instr,
        output F_PC, D_IR, D_PC, D_PC8
    );
endinterface

// File: rtl/ifu_dreg.sv
// ifu_dreg: fetch PC and IF/ID register; next PC comes from the instruction in D,
// so the instruction already in F is the delay slot and is never squashed.
module ifu_dreg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [2:0]  NPC_ADD4 = 3'd0,
    parameter logic [2:0]  NPC_BEQ  = 3'd1,
    parameter logic [2:0]  NPC_JAL  = 3'd2,
    parameter logic [2:0]  NPC_JR   = 3'd3
) (
    input logic       clk,
    input logic       reset,
    ifu_dreg_if.slave bus
);
    logic [31:0] r_f_pc, r_d_ir, r_d_pc;
    logic [31:0] w_pc4, w_br, w_jal, w_npc;
    assign w_pc4 = r_f_pc + 32'd4;
    assign w_br  = r_d_pc + 32'd4 + {{14{r_d_ir[15]}}, r_d_ir[15:0], 2'b00};
    assign w_jal = {r_d_pc[31:28], r_d_ir[25:0], 2'b00};
    always_comb begin
        w_npc = w_pc4;
        case (bus.D_NPCOp)
            NPC_ADD4: w_npc = w_pc4;
            NPC_BEQ:  w_npc = bus.D_cmp_eq ? w_br : w_pc4;
            NPC_JAL:  w_npc = w_jal;
            NPC_JR:   w_npc = bus.D_rs_data;
            default:  w_npc = w_pc4;
        endcase
    end
    // A stalled edge drops the redirect; it is recomputed once the D operands are valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_f_pc <= PC_RESET;
            r_d_ir <= 32'd0;
            r_d_pc <= PC_RESET;
        end else if (!bus.stall) begin
            r_f_pc <= w_npc;
            r_d_ir <= bus.F_instr;
            r_d_pc <= r_f_pc;
        end
    end
    assign bus.F_PC  = r_f_pc;
    assign bus.D_IR  = r_d_ir;
    assign bus.D_PC  = r_d_pc;
    assign bus.D_PC8 = r_d_pc + 32'd8;
endmodule

// File: tb/tb_ifu_dreg.sv
// tb_ifu_dreg: directed vectors with hand-computed post-edge state, checked
// through a scoreboard queue by an independent monitor process.
module tb_ifu_dreg;
    logic clk = 1'b0;
    logic reset;
    ifu_dreg_if bus();
    ifu_dreg dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] f_pc;
        logic [31:0] d_ir;
        logic [31:0] d_pc;
        logic [31:0] d_pc8;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic stl, input logic [2:0] op, input logic cmp,
                       input logic [31:0] rs, input logic [31:0] instr,
                       input logic [31:0] f, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] pc8);
        @(negedge clk);
        reset         = rst;
        bus.stall     = stl;
        bus.D_NPCOp   = op;
        bus.D_cmp_eq  = cmp;
        bus.D_rs_data = rs;
        bus.F_instr   = instr;
        q.push_back('{f_pc: f, d_ir: ir, d_pc: pc, d_pc8: pc8});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("F_PC",  bus.F_PC,  e.f_pc);
                check("D_IR",  bus.D_IR,  e.d_ir);
                check("D_PC",  bus.D_PC,  e.d_pc);
                check("D_PC8", bus.D_PC8, e.d_pc8);
            end
        end
    end

    initial begin : watchdog
        repeat (500) @(posedge clk);
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1);
        end
    end

    initial begin : driver
        reset = 1'b1; bus.stall = 1'b0; bus.D_NPCOp = 3'd0; bus.D_cmp_eq = 1'b0;
        bus.D_rs_data = 32'd0; bus.F_instr = 32'd0;
        // reset, then sequential fetch
        row(1, 0, 3'd0, 0, 32'h0, 32'h1111_1111, 32'h3000, 32'h0,         32'h3000, 32'h3008);
        row(0, 0, 3'd0, 0, 32'h0, 32'h2000_0001, 32'h3004, 32'h2000_0001, 32'h3000, 32'h3008);
        row(0, 0, 3'd0, 0, 32'h0, 32'h1000_FFFF, 32'h3008, 32'h1000_FFFF, 32'h3004, 32'h300C);
        // beq imm=-1 taken: back to 0x3004, delay slot 0x3008 enters D
        row(0, 0, 3'd1, 1, 32'h0, 32'h2000_0002, 32'h3004, 32'h2000_0002, 32'h3008, 32'h3010);
        row(0, 0, 3'd0, 0, 32'h0, 32'h1000_FFFF, 32'h3008, 32'h1000_FFFF, 32'h3004, 32'h300C);
        // beq not taken
        row(0, 0, 3'd1, 0, 32'h0, 32'h2000_0002, 32'h300C, 32'h2000_0002, 32'h3008, 32'h3010);
        row(0, 0, 3'd0, 0, 32'h0, 32'h2000_0003, 32'h3010, 32'h2000_0003, 32'h300C, 32'h3014);
        row(0, 0, 3'd0, 0, 32'h0, 32'h0C00_0C10, 32'h3014, 32'h0C00_0C10, 32'h3010, 32'h3018);
        // jal target 0x3040
        row(0, 0, 3'd2, 0, 32'h0, 32'h2000_0004, 32'h3040, 32'h2000_0004, 32'h3014, 32'h301C);
        row(0, 0, 3'd0, 0, 32'h0, 32'h03E0_0008, 32'h3044, 32'h03E0_0008, 32'h3040, 32'h3048);
        // jr held off by a two-cycle stall
        row(0, 1, 3'd3, 0, 32'h3100, 32'h2000_0005, 32'h3044, 32'h03E0_0008, 32'h3040, 32'h3048);
        row(0, 1, 3'd3, 0, 32'h3100, 32'h2000_0005, 32'h3044, 32'h03E0_0008, 32'h3040, 32'h3048);
        row(0, 0, 3'd3, 0, 32'h3100, 32'h2000_0005, 32'h3100, 32'h2000_0005, 32'h3044, 32'h304C);
        row(0, 0, 3'd0, 0, 32'h0, 32'h2000_0006, 32'h3104, 32'h2000_0006, 32'h3100, 32'h3108);
        // undefined op code 7 acts as ADD4
        row(0, 0, 3'd7, 1, 32'h0, 32'h2000_0007, 32'h3108, 32'h2000_0007, 32'h3104, 32'h310C);
        // reset overrides stall and jr
        row(1, 1, 3'd3, 0, 32'h1234_5679, 32'h2000_0007, 32'h3000, 32'h0, 32'h3000, 32'h3008);
        // unaligned jr passes through, then op 4 acts as ADD4
        row(0, 0, 3'd3, 0, 32'h1234_5679, 32'h2000_0008, 32'h1234_5679, 32'h2000_0008, 32'h3000, 32'h3008);
        row(0, 0, 3'd4, 1, 32'h0, 32'h2000_0009, 32'h1234_567D, 32'h2000_0009, 32'h1234_5679, 32'h1234_5681);
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
